// File: rtl/unidade_busca_pkg.sv
// unidade_busca_pkg: widths, queue entry and FSM state
// shared by the fetch unit and its prefetch queue.
package unidade_busca_pkg;

    localparam int LARGURA_END  = 8;
    localparam int LARGURA_INST = 8;

    typedef struct packed {
        logic [LARGURA_END-1:0]  pc;
        logic [LARGURA_INST-1:0] instrucao;
    } entrada_fila_t;

    typedef enum logic {
        ATIVO  = 1'b0,
        PARADO = 1'b1
    } estado_t;

endpackage

// File: rtl/unidade_busca_fila.sv
// fila_busca: circular prefetch queue holding {pc, instrucao}.
// Depth must be a power of two so the pointers wrap naturally.
module fila_busca
    import unidade_busca_pkg::*;
#(
    parameter int PROF_FILA = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entrada_fila_t entrada,
    output logic          full,
    output logic          empty,
    output entrada_fila_t head
);

    localparam int LP = $clog2(PROF_FILA);
    localparam logic [LP:0] CONT_CHEIA = (LP+1)'(PROF_FILA);
    localparam logic [LP:0] CONT_UM    = (LP+1)'(1);
    localparam logic [LP-1:0] PTR_UM   = LP'(1);

    entrada_fila_t  mem [PROF_FILA];
    logic [LP-1:0]  rd_ptr;
    logic [LP-1:0]  wr_ptr;
    logic [LP:0]    cont;
    logic           faz_push;
    logic           faz_pop;

    assign full     = (cont == CONT_CHEIA);
    assign empty    = (cont == '0);
    assign head     = mem[rd_ptr];
    assign faz_pop  = pop & ~empty;
    assign faz_push = push & (~full | faz_pop);

    // Pointer and occupancy update; flush empties the queue at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cont   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cont   <= '0;
        end else begin
            if (faz_push) wr_ptr <= wr_ptr + PTR_UM;
            if (faz_pop)  rd_ptr <= rd_ptr + PTR_UM;
            case ({faz_push, faz_pop})
                2'b10:   cont <= cont + CONT_UM;
                2'b01:   cont <= cont - CONT_UM;
                default: cont <= cont;
            endcase
        end
    end

    // Entry storage; contents past the tail are don't-care.
    always_ff @(posedge clk) begin
        if (faz_push && !flush) mem[wr_ptr] <= entrada;
    end

endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch unit with fetch PC, run/stop
// FSM, redirect handling and a small prefetch queue.
module unidade_busca
    import unidade_busca_pkg::*;
#(
    parameter logic [LARGURA_END-1:0] PC_INICIAL = 8'h00,
    parameter int                     PROF_FILA  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [LARGURA_END-1:0]  endereco,
    input  logic [LARGURA_INST-1:0] instrucao,
    output logic                    inst_valid,
    output logic [LARGURA_INST-1:0] inst_data,
    output logic [LARGURA_END-1:0]  inst_pc,
    input  logic                    inst_ready,
    input  logic                    desvio_en,
    input  logic [LARGURA_END-1:0]  desvio_alvo,
    input  logic                    parar
);

    localparam logic [LARGURA_END-1:0] PC_UM = LARGURA_END'(1);

    logic [LARGURA_END-1:0] pc_busca;
    estado_t                estado;
    logic                   push;
    logic                   pop;
    logic                   cheia;
    logic                   vazia;
    entrada_fila_t          nova;
    entrada_fila_t          cabeca;

    assign endereco   = pc_busca;
    assign inst_valid = ~vazia;
    assign inst_data  = inst_valid ? cabeca.instrucao : '0;
    assign inst_pc    = inst_valid ? cabeca.pc : '0;
    assign pop        = inst_valid & inst_ready;

    // A redirect blocks the enqueue; a full queue only accepts
    // when its head leaves in the same cycle.
    assign push = (estado == ATIVO) & ~parar & ~desvio_en
                & (~cheia | pop);

    // Pack the memory word with the address it came from.
    always_comb begin
        nova           = '0;
        nova.pc        = pc_busca;
        nova.instrucao = instrucao;
    end

    // Fetch PC and run/stop FSM; redirect wins over normal advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_busca <= PC_INICIAL;
            estado   <= ATIVO;
        end else begin
            unique case (estado)
                ATIVO:  if (parar)  estado <= PARADO;
                PARADO: if (!parar) estado <= ATIVO;
                default:            estado <= ATIVO;
            endcase
            if (desvio_en)
                pc_busca <= desvio_alvo;
            else if (push)
                pc_busca <= pc_busca + PC_UM;
        end
    end

    fila_busca #(
        .PROF_FILA (PROF_FILA)
    ) u_fila (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (desvio_en),
        .entrada (nova),
        .full    (cheia),
        .empty   (vazia),
        .head    (cabeca)
    );

endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: directed scenarios plus random traffic checked
// against a queue-based behavioural model of the fetch unit.
module tb_unidade_busca;

    localparam logic [7:0] PC0  = 8'h00;
    localparam int         PROF = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] endereco;
    logic [7:0] instrucao;
    logic       inst_valid;
    logic [7:0] inst_data;
    logic [7:0] inst_pc;
    logic       inst_ready;
    logic       desvio_en;
    logic [7:0] desvio_alvo;
    logic       parar;

    logic [7:0] mem [256];

    typedef struct {
        logic [7:0] pc;
        logic [7:0] d;
    } ent_t;

    ent_t       fila [$];
    logic [7:0] m_pc;
    bit         m_parado;

    int n_assert = 0;
    int n_falhas = 0;

    always #5 clk = ~clk;

    assign instrucao = mem[endereco];

    unidade_busca #(
        .PC_INICIAL (PC0),
        .PROF_FILA  (PROF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .endereco    (endereco),
        .instrucao   (instrucao),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .desvio_en   (desvio_en),
        .desvio_alvo (desvio_alvo),
        .parar       (parar)
    );

    task automatic verifica(string tag, logic [7:0] obs, logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_falhas++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compara();
        logic [7:0] e_v;
        logic [7:0] e_d;
        logic [7:0] e_p;
        e_v = (fila.size() > 0) ? 8'h01 : 8'h00;
        e_d = (fila.size() > 0) ? fila[0].d : 8'h00;
        e_p = (fila.size() > 0) ? fila[0].pc : 8'h00;
        verifica("m_valid", {7'b0, inst_valid}, e_v);
        verifica("m_data", inst_data, e_d);
        verifica("m_pc", inst_pc, e_p);
        verifica("m_endereco", endereco, m_pc);
    endtask

    // One clock of the fetch rules, in terms of a FIFO of fetched words.
    task automatic modelo(logic rd, logic dv, logic [7:0] alvo, logic pr);
        ent_t e;
        if (fila.size() > 0 && rd) void'(fila.pop_front());
        if (dv) begin
            fila.delete();
            m_pc = alvo;
        end else if (!m_parado && !pr && fila.size() < PROF) begin
            e.pc = m_pc;
            e.d  = mem[m_pc];
            fila.push_back(e);
            m_pc = m_pc + 8'd1;
        end
        m_parado = pr;
    endtask

    task automatic passo(logic rd, logic dv, logic [7:0] alvo, logic pr);
        inst_ready  = rd;
        desvio_en   = dv;
        desvio_alvo = alvo;
        parar       = pr;
        @(posedge clk);
        modelo(rd, dv, alvo, pr);
        #1;
        compara();
    endtask

    task automatic reseta();
        #2;
        reset = 1'b1;
        fila.delete();
        m_pc     = PC0;
        m_parado = 1'b0;
        #1;
        verifica("rst_async_valid", {7'b0, inst_valid}, 8'h00);
        compara();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] prog [4];
        logic [7:0] salvo;
        logic [7:0] esp;
        prog[0] = 8'hB0;
        prog[1] = 8'hB5;
        prog[2] = 8'hBA;
        prog[3] = 8'hBF;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) mem[i] = prog[i];

        reset       = 1'b1;
        inst_ready  = 1'b0;
        desvio_en   = 1'b0;
        desvio_alvo = 8'h00;
        parar       = 1'b0;
        m_pc        = PC0;
        m_parado    = 1'b0;
        #1;
        verifica("rst_valid", {7'b0, inst_valid}, 8'h00);
        verifica("rst_data", inst_data, 8'h00);
        verifica("rst_pc", inst_pc, 8'h00);
        verifica("rst_endereco", endereco, PC0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back delivery of the test program.
        for (int i = 0; i < 4; i++) begin
            passo(1'b1, 1'b0, 8'h00, 1'b0);
            verifica("seq_pc", inst_pc, 8'(i));
            verifica("seq_data", inst_data, prog[i]);
        end

        // Redirect to 14 while BF is being accepted.
        passo(1'b1, 1'b1, 8'h14, 1'b0);
        verifica("desv_bolha", {7'b0, inst_valid}, 8'h00);
        passo(1'b1, 1'b0, 8'h00, 1'b0);
        verifica("desv_pc", inst_pc, 8'h14);
        verifica("desv_data", inst_data, mem[8'h14]);

        // Backpressure: queue fills and fetch address stalls.
        reseta();
        for (int i = 0; i < 5; i++) passo(1'b0, 1'b0, 8'h00, 1'b0);
        verifica("cheia_endereco", endereco, 8'h02);
        verifica("cheia_valid", {7'b0, inst_valid}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            verifica("drena_data", inst_data, prog[i]);
            passo(1'b1, 1'b0, 8'h00, 1'b0);
        end

        // Redirect across the address wrap.
        passo(1'b1, 1'b1, 8'hFE, 1'b0);
        verifica("wrap_bolha", {7'b0, inst_valid}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            passo(1'b1, 1'b0, 8'h00, 1'b0);
            esp = 8'hFE + 8'(i);
            verifica("wrap_pc", inst_pc, esp);
        end

        // Stop for three cycles: queue drains, address freezes.
        salvo = endereco;
        for (int i = 0; i < 3; i++) passo(1'b1, 1'b0, 8'h00, 1'b1);
        verifica("parar_valid", {7'b0, inst_valid}, 8'h00);
        verifica("parar_endereco", endereco, salvo);
        passo(1'b1, 1'b0, 8'h00, 1'b0);
        passo(1'b1, 1'b0, 8'h00, 1'b0);
        verifica("retoma_valid", {7'b0, inst_valid}, 8'h01);
        verifica("retoma_pc", inst_pc, salvo);

        // Reset with a full queue.
        for (int i = 0; i < 3; i++) passo(1'b0, 1'b0, 8'h00, 1'b0);
        verifica("pre_rst_valid", {7'b0, inst_valid}, 8'h01);
        reseta();
        passo(1'b1, 1'b0, 8'h00, 1'b0);
        verifica("pos_rst_pc", inst_pc, PC0);
        verifica("pos_rst_data", inst_data, mem[PC0]);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            passo(1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 9) == 0),
                  8'($urandom),
                  1'($urandom_range(0, 6) == 0));
            if ($urandom_range(0, 199) == 0) reseta();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_falhas);
        $finish;
    end

endmodule

// File: doc/unidade_busca.md
UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 Parameter PC_INICIAL, default 8'h00: fetch address loaded on reset.
REQ-002 Parameter PROF_FILA, default 2: prefetch queue depth in entries; legal values 2 and 4.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset exists.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 endereco  output  8  address driven to the combinational instruction memory.
REQ-007 instrucao  input  8  memory data; valid in the same cycle as endereco.
REQ-008 inst_valid  output  1  queue head holds a valid instruction.
REQ-009 inst_data  output  8  instruction at the queue head.
REQ-010 inst_pc  output  8  address the head instruction was fetched from.
REQ-011 inst_ready  input  1  the consumer accepts the head this cycle.
REQ-012 desvio_en  input  1  redirect request, one cycle pulse.
REQ-013 desvio_alvo  input  8  redirect target address.
REQ-014 parar  input  1  suspends fetching while high.

Function
REQ-015 endereco SHALL equal pc_busca combinationally at all times.
REQ-016 Handshake: the head SHALL be consumed in a cycle when inst_valid and inst_ready are both high.
REQ-017 When inst_valid is low, inst_data and inst_pc SHALL be 8'h00.
REQ-018 State machine: ATIVO and PARADO states.
- In ATIVO with parar low, the block SHALL enqueue {pc_busca, instrucao} at the edge if the queue is not full, or if it is full and consumed this cycle.
- On enqueue, pc_busca SHALL advance by 1.
REQ-019 pc_busca SHALL wrap from 8'hFF to 8'h00 with no flag raised.
REQ-020 ATIVO->PARADO when parar is high; PARADO->ATIVO when parar is low. No enqueue occurs in PARADO. The queue SHALL continue to drain in PARADO.
REQ-021 Fetch latency: an address fetched at edge N SHALL be visible at the head from cycle N+1 if the queue was empty; there is no combinational bypass from instrucao to inst_data.
REQ-022 Throughput: with inst_ready held high and no redirect, one instruction SHALL be delivered per cycle.
REQ-023 A full queue with a simultaneous dequeue and enqueue SHALL keep its occupancy unchanged.
REQ-024 Redirect on desvio_en at edge N:
- A head handshake in that cycle still counts as consumed.
- All queue entries SHALL be discarded.
- No enqueue occurs in that cycle.
- pc_busca SHALL be loaded with desvio_alvo.
- inst_valid SHALL be 0 in cycle N+1; the target is enqueued at edge N+1 and valid in cycle N+2.
REQ-025 desvio_en SHALL take priority over parar for loading pc_busca. The state transition on parar still applies.
REQ-026 Queue order SHALL be strict FIFO; no entry is duplicated or dropped except by a redirect.

Reset
REQ-027 On reset assertion, asynchronously:
- pc_busca=PC_INICIAL, state=ATIVO, queue empty.
- inst_valid=0, inst_data=8'h00, inst_pc=8'h00.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight entries.
REQ-029 The first fetch after reset release SHALL be from PC_INICIAL at the first rising edge with reset low.

Structure
REQ-030 A shared package SHALL hold:
- LARGURA_END=8 and LARGURA_INST=8.
- The queue-entry typedef {pc, instrucao}.
- The state enumeration {ATIVO, PARADO}.
REQ-031 The queue SHALL be a sub-module fila_busca, parameterised by PROF_FILA, with push, pop, flush, full, empty and head ports. unidade_busca contains the PC, the FSM and the push/pop control.

Verification
REQ-032 Test program: memory locations 0..3 hold B0, B5, BA, BF.
- Release reset with inst_ready=1 -> cycles 1..4 deliver (pc,data) = (00,B0), (01,B5), (02,BA), (03,BF) back-to-back.
REQ-033 inst_ready=0 for 5 cycles after reset -> queue fills to PROF_FILA, then endereco holds 02. On release, B0, B5, BA are delivered in order with no loss or duplication.
REQ-034 desvio_en=1 with desvio_alvo=8'h14 while the head is (03,BF) and inst_ready=1 -> BF is accepted; next cycle inst_valid=0; the following cycle (14, mem[14]) is at the head.
REQ-035 Redirect to 8'hFE with inst_ready=1 -> head sequence FE, FF, 00, 01.
REQ-036 parar=1 for 3 cycles with inst_ready=1 -> the queue drains, then inst_valid=0 and endereco is frozen. After parar falls, fetching resumes at the frozen address.
REQ-037 reset pulsed while the queue is full -> inst_valid=0 immediately (asynchronous), and the first head after release is (PC_INICIAL, mem[PC_INICIAL]).
